fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the imem word address.
- Captures the combinational imem read data into a 2-entry instruction buffer.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_a  out  32  byte address to instruction memory; equals pc_q, bits [1:0] always 0.
- imem_rd  in  32  instruction word returned combinationally for imem_a.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  redirect target byte address.
- dec_valid  out  1  buffer head holds a valid instruction.
- dec_ready  in  1  decode accepts the head this cycle.
- dec_instr  out  32  head instruction word.
- dec_pc  out  32  head instruction byte address.
- fetch_fault  out  1  sticky misaligned-redirect fault; fetching halted.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low, port reset, clock port clk.
- Reset values: pc_q=RESET_PC; buffer empty (count=0); dec_valid=0; dec_instr=0; dec_pc=0; fetch_fault=0.
- imem interface: imem_a=pc_q, combinational.
- Pop: pop = dec_valid & dec_ready.
- Fetch: fetch = !redirect_valid & !fetch_fault & (count<2 | pop).
- On fetch: push {pc_q, imem_rd} at the tail; pc_q <= pc_q+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Latency: an instruction fetched in cycle N is on dec_* in cycle N+1 at the earliest, and stays there until popped.
- FIFO order: strictly in order. Push and pop in the same cycle keeps count unchanged.
- Full buffer with no pop: no fetch; pc_q holds.
- Handshake rules: dec_instr and dec_pc must be stable while dec_valid=1 and dec_ready=0. dec_ready while dec_valid=0 has no effect.
- Redirect has highest priority:
  - Buffer is cleared (count=0) and no push occurs that cycle.
  - A pop in the same cycle is still honoured; decode's acceptance stands.
  - pc_q <= redirect_pc.
  - dec_valid=0 in cycle N+1; target instruction appears no earlier than N+2.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - Buffer is flushed and pc_q <= {redirect_pc[31:2],2'b00}.
  - fetch_fault <= 1; no further fetches.
  - Fault clears only on a subsequent aligned redirect (or reset), which resumes fetching next cycle.
- Back-to-back redirects: the last one wins; each flushes.
- Reset mid-operation: immediate return to reset values regardless of state; no partial push survives.
- States: RUN (fetching) and FAULT (fetch_fault=1).
  - RUN->FAULT on misaligned redirect.
  - FAULT->RUN on aligned redirect.
- imem_rd is sampled only on fetch cycles. Addresses beyond imem depth are not checked here.

Decomposition:
- Shared package holds:
  - RESET_PC default and the INSTR_W=32 / XLEN=32 constants.
  - A fetch-packet type {pc[31:0], instr[31:0]}.
- One sub-module: fetch_buf, a 2-entry synchronous FIFO with flush, push, pop and count.
- PC register and fault logic stay in fetch_unit.

Test Plan:
- Reset, dec_ready=1 constant, imem returns 32'h0000_0013 at every address -> dec_pc sequence 0,4,8,C on cycles 1..4; dec_valid=1 from cycle 1.
- dec_ready=0 for 5 cycles -> count reaches 2; pc_q stops at 8; dec_pc=0 held stable. Release dec_ready -> dec_pc 0,4,8 with no gap or duplicate.
- Redirect_pc=32'h40 while buffer holds 2 entries -> dec_valid=0 next cycle, then dec_pc=32'h40, 32'h44. Flushed PCs never appear.
- Redirect_pc=32'h42 -> fetch_fault=1, dec_valid=0 indefinitely. Then redirect_pc=32'h80 -> fault clears, dec_pc=32'h80 two cycles later.
- Start with RESET_PC=32'hFFFF_FFF8 -> dec_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset low mid-stream with a full buffer -> dec_valid=0 and pc_q=RESET_PC asynchronously; fetch restarts from RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch slice.
package fetch_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order instruction buffer; flush clears it and overrides push.
module fetch_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  input  logic        pop,
  output logic        head_valid,
  output logic [31:0] head_pc,
  output logic [31:0] head_instr,
  output logic [1:0]  count
);

  fetch_pkt_t mem_q [2];
  fetch_pkt_t mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       pop_eff;
  logic       push_eff;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop_eff  = pop && (count_q != 2'd0);
    push_eff = push && ((count_q != 2'd2) || pop_eff);

    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push_eff) begin
        mem_d[wr_ptr_q] = '{pc: push_pc, instr: push_instr};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_eff) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid = (count_q != 2'd0);
  assign head_pc    = mem_q[rd_ptr_q].pc;
  assign head_instr = mem_q[rd_ptr_q].instr;
  assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives imem, buffers fetched words for decode and
// handles execute redirects including the sticky misaligned-target fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        fetch_fault
);

  localparam logic [1:0] FULL_CNT = BUF_DEPTH[1:0];

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic         pop;
  logic         fetch;
  logic [1:0]   count;

  always_comb begin
    pop     = dec_valid && dec_ready;
    fetch   = !redirect_valid && (state_q == ST_RUN) && ((count < FULL_CNT) || pop);
    pc_d    = pc_q;
    state_d = state_q;
    fault_d = fault_q;

    // Redirect outranks fetch; a misaligned target still moves the PC (word-aligned) but parks the FSM.
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      if (is_aligned(redirect_pc)) begin
        state_d = ST_RUN;
        fault_d = 1'b0;
      end else begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
    end else if (fetch) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_buf u_buf (
    .clk        (clk),
    .rst_n      (reset),
    .flush      (redirect_valid),
    .push       (fetch),
    .push_pc    (pc_q),
    .push_instr (imem_rd),
    .pop        (pop),
    .head_valid (dec_valid),
    .head_pc    (dec_pc),
    .head_instr (dec_instr),
    .count      (count)
  );

  assign imem_a      = pc_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        fetch_fault;
  logic        hash_mode;

  logic        reset2;
  logic        ready2 = 1'b1;
  logic        redir2 = 1'b0;
  logic [31:0] redir_pc2 = 32'h0;
  logic [31:0] imem_rd2 = 32'h0000_0013;
  logic [31:0] imem_a2;
  logic        dec_valid2;
  logic [31:0] dec_instr2;
  logic [31:0] dec_pc2;
  logic        fetch_fault2;

  int n_checks = 0;
  int n_errors = 0;

  ent_t        m_q [$];
  logic [31:0] m_pc    = 32'h0;
  logic        m_fault = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic h);
    return h ? ((a * 32'h9E37_79B1) ^ 32'h0000_0013) : 32'h0000_0013;
  endfunction

  assign imem_rd = mem_word(imem_a, hash_mode);

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_a         (imem_a),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fetch_fault    (fetch_fault)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .reset          (reset2),
    .imem_a         (imem_a2),
    .imem_rd        (imem_rd2),
    .redirect_valid (redir2),
    .redirect_pc    (redir_pc2),
    .dec_valid      (dec_valid2),
    .dec_ready      (ready2),
    .dec_instr      (dec_instr2),
    .dec_pc         (dec_pc2),
    .fetch_fault    (fetch_fault2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: decode takes the head, a redirect empties everything,
  // otherwise one word is fetched whenever there is room.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_pc    = 32'h0;
      m_fault = 1'b0;
    end else begin
      if (m_q.size() != 0 && dec_ready) void'(m_q.pop_front());
      if (redirect_valid) begin
        m_q.delete();
        m_pc    = {redirect_pc[31:2], 2'b00};
        m_fault = (redirect_pc[1:0] != 2'b00);
      end else if (!m_fault && m_q.size() < 2) begin
        m_q.push_back('{pc: m_pc, instr: mem_word(m_pc, hash_mode)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_valid", {31'b0, dec_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("cmp_pc", dec_pc, m_q[0].pc);
      chk("cmp_instr", dec_instr, m_q[0].instr);
    end
    chk("cmp_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    chk("cmp_imem_a", imem_a, m_pc);
  end

  logic [31:0] exp_wrap [3];
  logic [31:0] r;

  initial begin
    exp_wrap[0] = 32'hFFFF_FFF8;
    exp_wrap[1] = 32'hFFFF_FFFC;
    exp_wrap[2] = 32'h0000_0000;
    reset = 1'b0; reset2 = 1'b0;
    dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; hash_mode = 1'b0;
    repeat (2) tick();
    chk("rst_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_instr", dec_instr, 32'd0);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_imem_a", imem_a, 32'd0);
    chk("rst_imem_a_wrap", imem_a2, 32'hFFFF_FFF8);

    reset = 1'b1; reset2 = 1'b1; dec_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("stream_valid", {31'b0, dec_valid}, 32'd1);
      chk("stream_pc", dec_pc, 32'(4 * (c - 1)));
      chk("stream_instr", dec_instr, 32'h0000_0013);
      if (c <= 3) chk("wrap_pc", dec_pc2, exp_wrap[c-1]);
    end

    reset = 1'b0;
    tick();
    reset = 1'b1; dec_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("stall_valid", {31'b0, dec_valid}, 32'd1);
      chk("stall_pc", dec_pc, 32'h0);
    end
    chk("stall_imem_a", imem_a, 32'h8);
    dec_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk("release_pc", dec_pc, 32'(4 * k));
    end

    dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("redir_valid", {31'b0, dec_valid}, 32'd0);
    chk("redir_imem_a", imem_a, 32'h40);
    redirect_valid = 1'b0; dec_ready = 1'b1;
    tick();
    chk("redir_pc0", dec_pc, 32'h40);
    tick();
    chk("redir_pc1", dec_pc, 32'h44);

    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    chk("mis_imem_a", imem_a, 32'h40);
    redirect_valid = 1'b0;
    repeat (4) begin
      tick();
      chk("mis_valid", {31'b0, dec_valid}, 32'd0);
      chk("mis_fault_hold", {31'b0, fetch_fault}, 32'd1);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    chk("clr_fault", {31'b0, fetch_fault}, 32'd0);
    chk("clr_valid", {31'b0, dec_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    chk("clr_pc", dec_pc, 32'h80);

    dec_ready = 1'b0;
    repeat (3) tick();
    chk("full_pc", dec_pc, 32'h80);
    #3 reset = 1'b0;
    #1;
    chk("async_valid", {31'b0, dec_valid}, 32'd0);
    chk("async_imem_a", imem_a, 32'h0);
    tick();
    reset = 1'b1; dec_ready = 1'b1;
    tick();
    chk("restart_pc0", dec_pc, 32'h0);
    tick();
    chk("restart_pc1", dec_pc, 32'h4);

    hash_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset = 1'b0;
      dec_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 15) == 0);
      r = $urandom;
      case ($urandom_range(0, 9))
        0, 1:    redirect_pc = r;
        2:       redirect_pc = 32'hFFFF_FFF0;
        default: redirect_pc = {r[31:2], 2'b00};
      endcase
    end
    reset = 1'b1; redirect_valid = 1'b0; dec_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
